// File: rtl/mips_pkg.sv
// Shared constants and the ID/EX record for the MIPS pipeline.
// Holds ALU control codes, ALUOp/funct encodings and id_ctrl bit positions.
package mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SRL = 3'b100;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam int         ALUOP_RTYPE_BIT = 1;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_REGDST   = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_SHIFT    = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic        regdst;
    logic        alusrc;
    logic        shift;
    logic [1:0]  aluop;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
  } idex_t;

  // EX/MEM wins over MEM/WB; r0 is hardwired zero so it is never a forwarding target.
  function automatic logic [31:0] forward(
    input logic [4:0]  src,
    input logic [31:0] regval,
    input logic        exm_regwrite,
    input logic [4:0]  exm_rd,
    input logic [31:0] exm_result,
    input logic        wb_regwrite,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (exm_regwrite && exm_rd != 5'd0 && exm_rd == src)
      return exm_result;
    else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == src)
      return wb_data;
    else
      return regval;
  endfunction

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control decoder: (aluop, funct) -> 3-bit ALU code.
// Unknown R-type funct falls back to add and raises an unqualified illegal flag.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] ctl,
  output logic       illegal
);

  always_comb begin
    ctl     = ALU_ADD;
    illegal = 1'b0;
    if (aluop[ALUOP_RTYPE_BIT]) begin
      case (funct)
        FUNCT_ADD: ctl = ALU_ADD;
        FUNCT_SUB: ctl = ALU_SUB;
        FUNCT_AND: ctl = ALU_AND;
        FUNCT_OR:  ctl = ALU_OR;
        FUNCT_SLT: ctl = ALU_SLT;
        FUNCT_SRL: ctl = ALU_SRL;
        default:   illegal = 1'b1;
      endcase
    end else if (aluop == ALUOP_SUB) begin
      ctl = ALU_SUB;
    end else if (aluop == ALUOP_ADD) begin
      ctl = ALU_ADD;
    end
  end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with forwarding, load-use detection and ALU control.
// Everything downstream of the register is combinational within the EX cycle.
module idex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  input  logic [5:0]  id_funct,
  input  logic [8:0]  id_ctrl,
  input  logic        flush,
  input  logic        exm_regwrite,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        aluop0,
  output logic        aluop1,
  output logic        aluop2,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wreg,
  output logic [3:0]  ex_ctrl,
  output logic        illegal
);

  idex_t       q;
  idex_t       d;
  logic        bubble;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic [2:0]  ctl;
  logic        illegal_raw;

  assign stall  = q.memread && (q.rt != 5'd0) && ((q.rt == id_rs) || (q.rt == id_rt));
  assign bubble = stall || flush;

  // A bubble only needs its state-changing controls killed; data rides along harmlessly.
  always_comb begin
    d          = '0;
    d.regwrite = id_ctrl[CTRL_REGWRITE] && !bubble;
    d.memtoreg = id_ctrl[CTRL_MEMTOREG];
    d.memread  = id_ctrl[CTRL_MEMREAD] && !bubble;
    d.memwrite = id_ctrl[CTRL_MEMWRITE] && !bubble;
    d.regdst   = id_ctrl[CTRL_REGDST];
    d.alusrc   = id_ctrl[CTRL_ALUSRC];
    d.shift    = id_ctrl[CTRL_SHIFT];
    d.aluop    = id_ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    d.rs_data  = id_rs_data;
    d.rt_data  = id_rt_data;
    d.imm      = id_imm;
    d.rs       = id_rs;
    d.rt       = id_rt;
    d.rd       = id_rd;
    d.shamt    = id_shamt;
    d.funct    = id_funct;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else
      q <= d;
  end

  assign fwd_rs = forward(q.rs, q.rs_data, exm_regwrite, exm_rd, exm_result,
                          wb_regwrite, wb_rd, wb_data);
  assign fwd_rt = forward(q.rt, q.rt_data, exm_regwrite, exm_rd, exm_result,
                          wb_regwrite, wb_rd, wb_data);

  assign alu_a         = q.shift ? fwd_rt : fwd_rs;
  assign alu_b         = q.shift ? {27'b0, q.shamt} : (q.alusrc ? q.imm : fwd_rt);
  assign ex_store_data = fwd_rt;
  assign ex_wreg       = q.regdst ? q.rd : q.rt;
  assign ex_ctrl       = {q.regwrite, q.memtoreg, q.memread, q.memwrite};

  alu_control u_alu_control (
    .aluop   (q.aluop),
    .funct   (q.funct),
    .ctl     (ctl),
    .illegal (illegal_raw)
  );

  assign {aluop0, aluop1, aluop2} = ctl;
  assign illegal = illegal_raw && q.regwrite;

endmodule
